// File: rtl/btb_predictor_pkg.sv
// Shared types and helpers for the direct-mapped branch target buffer.
package btb_predictor_pkg;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_INC   = 2'd1,
    UPD_DEC   = 2'd2,
    UPD_ALLOC = 2'd3
  } upd_action_t;

  // Invalidation wins over a resolving branch; a not-taken miss leaves the table alone.
  function automatic upd_action_t decode_update(input logic valid, input logic inval,
                                                input logic hit, input logic taken);
    upd_action_t act;
    if (inval || !valid) begin
      act = UPD_NONE;
    end else if (hit) begin
      if (taken) begin
        act = UPD_INC;
      end else begin
        act = UPD_DEC;
      end
    end else if (taken) begin
      act = UPD_ALLOC;
    end else begin
      act = UPD_NONE;
    end
    return act;
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Next-value logic for a saturating up/down direction counter.
module btb_predictor_sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] count,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  // Step toward the requested direction, holding at either rail.
  always_comb begin
    next_count = count;
    if (inc && !dec) begin
      if (count != MAX_C) begin
        next_count = count + ONE_C;
      end else begin
        next_count = count;
      end
    end else if (dec && !inc) begin
      if (count != ZERO_C) begin
        next_count = count - ONE_C;
      end else begin
        next_count = count;
      end
    end else begin
      next_count = count;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and
// wrap-around resolve/mispredict statistics.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES      = 16,
  parameter int COUNTER_BITS = 2,
  parameter int PRED_MODE    = 1,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [31:0]           lookup_pc,
  output logic                  btb_hit,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [31:0]           next_fetch_pc,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic                  update_taken,
  input  logic [31:0]           update_target,
  input  logic                  update_mispredict,
  input  logic                  invalidate_all,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;
  localparam bit DYN_MODE_C = (PRED_MODE == 32'sd1);

  localparam logic [COUNTER_BITS-1:0] WEAK_TAKEN_C = COUNTER_BITS'(1'b1) << (COUNTER_BITS - 1);
  localparam logic [STAT_WIDTH-1:0]   STAT_ONE_C   = STAT_WIDTH'(1'b1);
  localparam logic [STAT_WIDTH-1:0]   STAT_ZERO_C  = {STAT_WIDTH{1'b0}};

  typedef struct packed {
    logic                    valid;
    logic [TAG_W-1:0]        tag;
    logic [31:0]             target;
    logic [COUNTER_BITS-1:0] counter;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET_C = '{
    valid:   1'b0,
    tag:     {TAG_W{1'b0}},
    target:  32'd0,
    counter: {COUNTER_BITS{1'b0}}
  };

  btb_entry_t              table_r [ENTRIES];
  logic [IDX-1:0]          lk_idx_s;
  logic [TAG_W-1:0]        lk_tag_s;
  logic [IDX-1:0]          up_idx_s;
  logic [TAG_W-1:0]        up_tag_s;
  logic                    up_hit_s;
  upd_action_t             up_act_s;
  logic [COUNTER_BITS-1:0] cnt_next_s;
  logic                    unused_pc_bits_s;

  assign lk_idx_s = lookup_pc[IDX+1:2];
  assign lk_tag_s = lookup_pc[31:IDX+2];
  assign up_idx_s = update_pc[IDX+1:2];
  assign up_tag_s = update_pc[31:IDX+2];
  assign unused_pc_bits_s = ^{lookup_pc[1:0], update_pc[1:0]};

  assign up_hit_s = table_r[up_idx_s].valid && (table_r[up_idx_s].tag == up_tag_s);
  assign up_act_s = decode_update(update_valid, invalidate_all, up_hit_s, update_taken);

  btb_predictor_sat_counter #(
    .WIDTH(COUNTER_BITS)
  ) u_sat_counter (
    .count      (table_r[up_idx_s].counter),
    .inc        (up_act_s == UPD_INC),
    .dec        (up_act_s == UPD_DEC),
    .next_count (cnt_next_s)
  );

  // Zero-latency fetch-side lookup; reads the table as it stood before this cycle's update.
  always_comb begin
    btb_hit       = 1'b0;
    pred_taken    = 1'b0;
    pred_target   = 32'd0;
    next_fetch_pc = lookup_pc + INSN_BYTES;
    if (table_r[lk_idx_s].valid && (table_r[lk_idx_s].tag == lk_tag_s)) begin
      btb_hit     = 1'b1;
      pred_target = table_r[lk_idx_s].target;
      if (DYN_MODE_C && table_r[lk_idx_s].counter[COUNTER_BITS-1]) begin
        pred_taken    = 1'b1;
        next_fetch_pc = table_r[lk_idx_s].target;
      end else begin
        pred_taken    = 1'b0;
        next_fetch_pc = lookup_pc + INSN_BYTES;
      end
    end else begin
      btb_hit       = 1'b0;
      pred_target   = 32'd0;
    end
  end

  // Table write port: bulk invalidate, counter training, target refresh, allocation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= ENTRY_RESET_C;
      end
    end else if (invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i].valid <= 1'b0;
      end
    end else begin
      case (up_act_s)
        UPD_INC: begin
          table_r[up_idx_s].counter <= cnt_next_s;
          table_r[up_idx_s].target  <= update_target;
        end
        UPD_DEC: begin
          table_r[up_idx_s].counter <= cnt_next_s;
        end
        UPD_ALLOC: begin
          table_r[up_idx_s] <= '{
            valid:   1'b1,
            tag:     up_tag_s,
            target:  update_target,
            counter: WEAK_TAKEN_C
          };
        end
        UPD_NONE: begin
          table_r[up_idx_s] <= table_r[up_idx_s];
        end
        default: begin
          table_r[up_idx_s] <= table_r[up_idx_s];
        end
      endcase
    end
  end

  // Statistics count every resolved branch, even one dropped by a same-cycle invalidate.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_lookups     <= STAT_ZERO_C;
      stat_mispredicts <= STAT_ZERO_C;
    end else begin
      if (update_valid) begin
        stat_lookups <= stat_lookups + STAT_ONE_C;
      end else begin
        stat_lookups <= stat_lookups;
      end
      if (update_valid && update_mispredict) begin
        stat_mispredicts <= stat_mispredicts + STAT_ONE_C;
      end else begin
        stat_mispredicts <= stat_mispredicts;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench: two btb_predictor configurations driven in lockstep and
// compared against an index/tag/counter model built from the behavioural rules.
module tb_btb_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        invalidate_all;

  logic        d_hit, d_taken;
  logic [31:0] d_target, d_next;
  logic [15:0] d_sl, d_sm;
  logic        a_hit, a_taken;
  logic [31:0] a_target, a_next;
  logic [3:0]  a_sl, a_sm;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  btb_predictor #(.ENTRIES(16), .COUNTER_BITS(2), .PRED_MODE(1), .STAT_WIDTH(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .btb_hit(d_hit), .pred_taken(d_taken), .pred_target(d_target), .next_fetch_pc(d_next),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .invalidate_all(invalidate_all), .stat_lookups(d_sl), .stat_mispredicts(d_sm));

  btb_predictor #(.ENTRIES(8), .COUNTER_BITS(3), .PRED_MODE(0), .STAT_WIDTH(4)) u_alt (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .btb_hit(a_hit), .pred_taken(a_taken), .pred_target(a_target), .next_fetch_pc(a_next),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .invalidate_all(invalidate_all), .stat_lookups(a_sl), .stat_mispredicts(a_sm));

  // ---------------- reference model (index 0 = u_dut, 1 = u_alt) ----------------
  localparam int CFG_ENT  [2] = '{16, 8};
  localparam int CFG_IB   [2] = '{4, 3};
  localparam int CFG_CB   [2] = '{2, 3};
  localparam int CFG_MODE [2] = '{1, 0};

  bit          m_val [2][256];
  logic [31:0] m_tag [2][256];
  logic [31:0] m_tgt [2][256];
  int          m_cnt [2][256];
  int          m_sl  [2];
  int          m_sm  [2];

  function automatic int m_idx(input int c, input logic [31:0] pc);
    return int'((pc >> 2) % 32'(CFG_ENT[c]));
  endfunction

  function automatic logic [31:0] m_tagof(input int c, input logic [31:0] pc);
    return pc >> (2 + CFG_IB[c]);
  endfunction

  function automatic bit m_hit(input int c, input logic [31:0] pc);
    return m_val[c][m_idx(c, pc)] && (m_tag[c][m_idx(c, pc)] == m_tagof(c, pc));
  endfunction

  function automatic bit m_taken(input int c, input logic [31:0] pc);
    return m_hit(c, pc) && (CFG_MODE[c] == 1) && (m_cnt[c][m_idx(c, pc)] >= (1 << (CFG_CB[c] - 1)));
  endfunction

  function automatic logic [31:0] m_target(input int c, input logic [31:0] pc);
    return m_hit(c, pc) ? m_tgt[c][m_idx(c, pc)] : 32'd0;
  endfunction

  function automatic logic [31:0] m_next(input int c, input logic [31:0] pc);
    return m_taken(c, pc) ? m_tgt[c][m_idx(c, pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_sl[c] = 0;
      m_sm[c] = 0;
      for (int i = 0; i < 256; i++) begin
        m_val[c][i] = 1'b0; m_tag[c][i] = 32'd0; m_tgt[c][i] = 32'd0; m_cnt[c][i] = 0;
      end
    end
  endtask

  task automatic m_apply(input logic uv, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mp, input logic inv);
    int ix;
    int mx;
    for (int c = 0; c < 2; c++) begin
      ix = m_idx(c, pc);
      mx = (1 << CFG_CB[c]) - 1;
      if (uv) begin
        m_sl[c]++;
        if (mp) m_sm[c]++;
      end
      if (inv) begin
        for (int i = 0; i < 256; i++) m_val[c][i] = 1'b0;
      end else if (uv) begin
        if (m_hit(c, pc)) begin
          if (tk) begin
            m_cnt[c][ix] = (m_cnt[c][ix] < mx) ? m_cnt[c][ix] + 1 : mx;
            m_tgt[c][ix] = tgt;
          end else begin
            m_cnt[c][ix] = (m_cnt[c][ix] > 0) ? m_cnt[c][ix] - 1 : 0;
          end
        end else if (tk) begin
          m_val[c][ix] = 1'b1;
          m_tag[c][ix] = m_tagof(c, pc);
          m_tgt[c][ix] = tgt;
          m_cnt[c][ix] = 1 << (CFG_CB[c] - 1);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_upd(input logic uv, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mp, input logic inv);
    update_valid = uv; update_pc = pc; update_taken = tk;
    update_target = tgt; update_mispredict = mp; invalidate_all = inv;
  endtask

  task automatic step();
    @(posedge CLK);
    m_apply(update_valid, update_pc, update_taken, update_target, update_mispredict, invalidate_all);
    @(negedge CLK);
    update_valid = 1'b0; update_mispredict = 1'b0; invalidate_all = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    lookup_pc = 32'h40;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK);
    #1;
    tests_run++; if (d_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %0b want 0", d_hit); end
    tests_run++; if (d_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_taken got %0b want 0", d_taken); end
    tests_run++; if (d_target !== 32'd0) begin tests_failed++; $display("FAIL reset_target got %h want 0", d_target); end
    tests_run++; if (d_next !== 32'h44) begin tests_failed++; $display("FAIL reset_next got %h want 44", d_next); end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tests_run++; if (d_sl !== 16'd0) begin tests_failed++; $display("FAIL reset_stat_lookups got %0d want 0", d_sl); end
    tests_run++; if (d_sm !== 16'd0) begin tests_failed++; $display("FAIL reset_stat_mispredicts got %0d want 0", d_sm); end
    tests_run++; if (a_hit !== 1'b0 || a_sl !== 4'd0) begin tests_failed++; $display("FAIL reset_alt got hit=%0b sl=%0d want 0/0", a_hit, a_sl); end
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    step();
    lookup_pc = 32'h40;
    #1;
    tests_run++; if (d_hit !== 1'b1) begin tests_failed++; $display("FAIL alloc_hit got %0b want 1", d_hit); end
    tests_run++; if (d_taken !== 1'b1) begin tests_failed++; $display("FAIL alloc_taken got %0b want 1", d_taken); end
    tests_run++; if (d_next !== 32'h100) begin tests_failed++; $display("FAIL alloc_next got %h want 100", d_next); end
    tests_run++; if (d_target !== 32'h100) begin tests_failed++; $display("FAIL alloc_target got %h want 100", d_target); end
    tests_run++; if (d_sl !== 16'd1) begin tests_failed++; $display("FAIL alloc_stat_lookups got %0d want 1", d_sl); end
    tests_run++; if (a_hit !== 1'b1 || a_taken !== 1'b0 || a_next !== 32'h44) begin
      tests_failed++; $display("FAIL static_mode got hit=%0b taken=%0b next=%h want 1/0/44", a_hit, a_taken, a_next);
    end
  endtask

  task automatic test_counter();
    // counter starts at 2: 1,0,0 then 1,2,3,3 then 2,1
    bit seq_tk  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit seq_exp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] want_next;
    for (int k = 0; k < 9; k++) begin
      set_upd(1'b1, 32'h40, seq_tk[k], 32'h100, 1'b0, 1'b0);
      step();
      lookup_pc = 32'h40;
      #1;
      want_next = seq_exp[k] ? 32'h100 : 32'h44;
      tests_run++; if (d_taken !== seq_exp[k] || d_next !== want_next) begin
        tests_failed++; $display("FAIL counter_step%0d got taken=%0b next=%h want %0b/%h", k, d_taken, d_next, seq_exp[k], want_next);
      end
      tests_run++; if (a_hit !== m_hit(1, 32'h40) || a_taken !== 1'b0) begin
        tests_failed++; $display("FAIL counter_alt_step%0d got hit=%0b taken=%0b", k, a_hit, a_taken);
      end
    end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h40, 1'b1, 32'h180, 1'b0, 1'b0);
    step();
    set_upd(1'b1, 32'h440, 1'b1, 32'h200, 1'b0, 1'b0);
    step();
    lookup_pc = 32'h40;
    #1;
    tests_run++; if (d_hit !== 1'b0 || d_next !== 32'h44) begin tests_failed++; $display("FAIL alias_old got hit=%0b next=%h want 0/44", d_hit, d_next); end
    lookup_pc = 32'h440;
    #1;
    tests_run++; if (d_hit !== 1'b1 || d_target !== 32'h200 || d_next !== 32'h200) begin
      tests_failed++; $display("FAIL alias_new got hit=%0b target=%h next=%h want 1/200/200", d_hit, d_target, d_next);
    end
  endtask

  task automatic test_same_cycle();
    int sl_before;
    set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b0);
    #1;
    tests_run++; if (d_hit !== 1'b0 || d_next !== 32'h44) begin tests_failed++; $display("FAIL rbw_same got hit=%0b next=%h want 0/44", d_hit, d_next); end
    step();
    tests_run++; if (d_hit !== 1'b1 || d_target !== 32'h300) begin tests_failed++; $display("FAIL rbw_next got hit=%0b target=%h want 1/300", d_hit, d_target); end
    sl_before = m_sl[0];
    set_upd(1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 1'b1);
    step();
    lookup_pc = 32'h80;
    #1;
    tests_run++; if (d_hit !== 1'b0) begin tests_failed++; $display("FAIL inval_dropped got hit=%0b want 0", d_hit); end
    lookup_pc = 32'h40;
    #1;
    tests_run++; if (d_hit !== 1'b0 || a_hit !== 1'b0) begin tests_failed++; $display("FAIL inval_cleared got hit=%0b alt=%0b want 0/0", d_hit, a_hit); end
    tests_run++; if (d_sl !== 16'(sl_before + 1)) begin tests_failed++; $display("FAIL inval_stat got %0d want %0d", d_sl, sl_before + 1); end
  endtask

  task automatic test_pc_wrap();
    lookup_pc = 32'hFFFF_FFFC;
    #1;
    tests_run++; if (d_next !== 32'd0) begin tests_failed++; $display("FAIL wrap_miss_next got %h want 0", d_next); end
    set_upd(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1000, 1'b0, 1'b0);
    step();
    tests_run++; if (d_hit !== 1'b1 || d_next !== 32'h1000) begin tests_failed++; $display("FAIL wrap_hit got hit=%0b next=%h want 1/1000", d_hit, d_next); end
    tests_run++; if (a_hit !== 1'b1 || a_next !== 32'd0) begin tests_failed++; $display("FAIL wrap_alt got hit=%0b next=%h want 1/0", a_hit, a_next); end
  endtask

  task automatic test_reset_mid_update();
    lookup_pc = 32'hFFFF_FFFC;
    set_upd(1'b1, 32'h40, 1'b1, 32'h700, 1'b1, 1'b0);
    #2 nRST = 1'b0;
    #1;
    tests_run++; if (d_hit !== 1'b0 || d_sl !== 16'd0) begin tests_failed++; $display("FAIL async_reset got hit=%0b sl=%0d want 0/0", d_hit, d_sl); end
    @(posedge CLK);
    @(negedge CLK);
    set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    nRST = 1'b1;
    m_reset();
    lookup_pc = 32'h40;
    #1;
    tests_run++; if (d_hit !== 1'b0 || a_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_discard got hit=%0b alt=%0b want 0/0", d_hit, a_hit); end
    tests_run++; if (d_sm !== 16'd0 || a_sm !== 4'd0) begin tests_failed++; $display("FAIL reset_discard_stat got %0d/%0d want 0/0", d_sm, a_sm); end
  endtask

  task automatic test_stat_wrap();
    for (int k = 0; k < 17; k++) begin
      set_upd(1'b1, 32'($urandom_range(0, 255)) << 2, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
    end
    tests_run++; if (a_sm !== 4'd1 || a_sl !== 4'd1) begin tests_failed++; $display("FAIL stat_wrap got sm=%0d sl=%0d want 1/1", a_sm, a_sl); end
    tests_run++; if (d_sm !== 16'd17 || d_sl !== 16'd17) begin tests_failed++; $display("FAIL stat_wide got sm=%0d sl=%0d want 17/17", d_sm, d_sl); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int k = 0; k < 400; k++) begin
      pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
      set_upd($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      lookup_pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 1) == 0) lookup_pc = pc;
      #1;
      tests_run++; if (d_hit !== m_hit(0, lookup_pc) || d_taken !== m_taken(0, lookup_pc)) begin
        tests_failed++; $display("FAIL rand%0d_pred pc=%h got hit=%0b taken=%0b", k, lookup_pc, d_hit, d_taken);
      end
      tests_run++; if (d_target !== m_target(0, lookup_pc) || d_next !== m_next(0, lookup_pc)) begin
        tests_failed++; $display("FAIL rand%0d_target pc=%h got %h/%h want %h/%h", k, lookup_pc, d_target, d_next, m_target(0, lookup_pc), m_next(0, lookup_pc));
      end
      tests_run++; if (a_hit !== m_hit(1, lookup_pc) || a_taken !== 1'b0 || a_next !== m_next(1, lookup_pc)) begin
        tests_failed++; $display("FAIL rand%0d_alt pc=%h got hit=%0b taken=%0b next=%h", k, lookup_pc, a_hit, a_taken, a_next);
      end
      step();
      tests_run++; if (d_sl !== 16'(m_sl[0]) || d_sm !== 16'(m_sm[0]) || a_sl !== 4'(m_sl[1]) || a_sm !== 4'(m_sm[1])) begin
        tests_failed++; $display("FAIL rand%0d_stats got %0d/%0d %0d/%0d", k, d_sl, d_sm, a_sl, a_sm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_pc_wrap();
    test_reset_mid_update();
    test_stat_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised successor to the pipeline's fixed branch predictor.
- Direct-mapped branch target buffer with per-entry N-bit saturating direction counters, selectable prediction mode, bulk invalidate, and wrap-around statistics counters.
- Sits beside the program counter. Fetch reads it combinationally every cycle; the EX stage updates it once a branch resolves.

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 2..256.
- COUNTER_BITS, 2: width of each direction counter, 1..4.
- PRED_MODE, 1: 0 = static not-taken, 1 = dynamic counter.
- STAT_WIDTH, 16: width of each statistics counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- lookup_pc  in  32  PC of the instruction being fetched.
- btb_hit  out  1  valid entry whose tag matches lookup_pc.
- pred_taken  out  1  prediction is taken.
- pred_target  out  32  stored target for the hit entry; 0 on miss.
- next_fetch_pc  out  32  pred_taken ? pred_target : lookup_pc + 4.
- update_valid  in  1  a branch resolved in EX this cycle.
- update_pc  in  32  PC of the resolved branch.
- update_taken  in  1  actual branch outcome.
- update_target  in  32  actual taken target.
- update_mispredict  in  1  EX flushed because of this branch.
- invalidate_all  in  1  clear all valid bits.
- stat_lookups  out  STAT_WIDTH  count of resolved branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredicted branches.

Behaviour:
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2]; pc[1:0] is ignored.
- Lookup path is purely combinational, zero latency.
  - btb_hit = valid[idx] && tag[idx] == lookup tag.
  - pred_taken = btb_hit && PRED_MODE == 1 && counter MSB == 1.
- Update happens on the rising edge of CLK when update_valid = 1.
  - Hit and taken: counter increments, saturating at 2^COUNTER_BITS - 1; target is overwritten.
  - Hit and not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss and taken: the entry is allocated or replaced. valid = 1, tag and target are written, counter = 2^(COUNTER_BITS-1) (weakly taken).
  - Miss and not taken: no table change.
- PRED_MODE = 0: the table still allocates and updates (btb_hit stays meaningful), but pred_taken is always 0.
- Read-before-write: a lookup and an update to the same index in the same cycle returns the pre-update contents. There is no bypass.
- invalidate_all clears every valid bit at the next edge.
  - It takes priority over an update in the same cycle; that update is dropped from the table.
  - Statistics still count that update.
- Statistics:
  - stat_lookups increments on each update_valid.
  - stat_mispredicts increments when update_valid && update_mispredict.
  - Both wrap from all-ones to 0; they are not cleared by invalidate_all.
- Reset (asynchronous): all valid = 0, counters = 0, tags and targets = 0, statistics = 0.
  - Outputs immediately read btb_hit = 0, pred_taken = 0, pred_target = 0, next_fetch_pc = lookup_pc + 4.
- Reset asserted mid-update discards the update.
- update_pc = 0xFFFFFFFC is legal; next_fetch_pc wraps to 0.

Decomposition:
- Shared cpu_types_pkg gains a btb_entry_t struct: valid, tag, target, counter. Tag and counter widths come from the instance parameters via a parametrised typedef inside the module.
- One natural sub-module: sat_counter (COUNTER_BITS wide, inc/dec, saturating), one per entry or a shared next-value function.

Test Plan:
- Reset, lookup_pc = 0x40 -> btb_hit = 0, pred_taken = 0, next_fetch_pc = 0x44; stat_lookups = 0.
- Update pc 0x40 taken, target 0x100, then lookup 0x40 -> btb_hit = 1, counter = 2, pred_taken = 1, next_fetch_pc = 0x100.
- Continue from the previous state (counter = 2). Two not-taken updates at 0x40 (counter 2->1->0), then a third -> counter stays 0, pred_taken = 0, next_fetch_pc = 0x44. Four taken updates -> counter saturates at 3.
- Alias with ENTRIES = 16: update 0x40 taken, then 0x440 taken target 0x200 -> lookup 0x40 gives btb_hit = 0; lookup 0x440 gives target 0x200.
- Same-cycle lookup and update on 0x40 (first allocation) -> lookup shows miss that cycle, hit the next cycle. invalidate_all with a simultaneous update -> all misses afterwards, stat_lookups still increments.
- STAT_WIDTH = 4: 17 updates with update_mispredict = 1 -> stat_mispredicts = 1, stat_lookups = 1. PRED_MODE = 0 instance after a taken update -> btb_hit = 1, pred_taken = 0.
